unidad_control_multiciclo: RTL

UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

---
 rtl/unidad_control_multiciclo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-style control unit: a Moore FSM (plus mem_listo gating in
// FETCH) that sequences fetch, decode, memory, R-type, branch, jump and
// optionally addi instructions through a shared-memory, single-ALU datapath.
// Optional feature: define SOPORTE_ADDI_EN to add the ADDI_EXEC/ADDI_WB states
// and accept opcode 001000; without it that opcode is flagged as invalid.
module unidad_control_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] codigo_op,
  input  logic       mem_listo,
  output logic       pc_escritura,
  output logic       pc_escritura_cond,
  output logic       iord,
  output logic       mem_lectura,
  output logic       mem_escritura,
  output logic       ir_escritura,
  output logic       mem_a_reg,
  output logic       reg_escritura,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_fuente,
  output logic [1:0] operacion_alu,
  output logic [3:0] estado,
  output logic       op_invalida
);

  // State codes are part of the external interface (estado output).
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
`ifdef SOPORTE_ADDI_EN
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
`endif

  // Opcodes recognised in DECODE.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef SOPORTE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // ALU source-B and ALU operation encodings.
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_CUATRO = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] PCF_ALU    = 2'b00;
  localparam logic [1:0] PCF_ALUOUT = 2'b01;
  localparam logic [1:0] PCF_JUMP   = 2'b10;

  logic [3:0] estado_q;
  logic [3:0] estado_d;
  logic [3:0] destino_decode;
  logic       opcode_valido;

  // Dispatch target for the opcode seen in DECODE; unknown opcodes return to FETCH.
  always_comb begin
    destino_decode = S_FETCH;
    opcode_valido  = 1'b1;
    unique case (codigo_op)
      OP_RTYPE:      destino_decode = S_EXEC_R;
      OP_LW, OP_SW:  destino_decode = S_MEM_ADDR;
      OP_BEQ:        destino_decode = S_BRANCH;
      OP_J:          destino_decode = S_JUMP;
`ifdef SOPORTE_ADDI_EN
      OP_ADDI:       destino_decode = S_ADDI_EXEC;
`endif
      default: begin
        destino_decode = S_FETCH;
        opcode_valido  = 1'b0;
      end
    endcase
  end

  // Next-state logic; memory states stall on mem_listo, unused codes recover to FETCH.
  always_comb begin
    estado_d = S_FETCH;
    case (estado_q)
      S_FETCH:     estado_d = mem_listo ? S_DECODE : S_FETCH;
      S_DECODE:    estado_d = destino_decode;
      S_MEM_ADDR:  estado_d = (codigo_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  estado_d = mem_listo ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    estado_d = S_FETCH;
      S_MEM_WRITE: estado_d = mem_listo ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    estado_d = S_R_WB;
      S_R_WB:      estado_d = S_FETCH;
      S_BRANCH:    estado_d = S_FETCH;
      S_JUMP:      estado_d = S_FETCH;
`ifdef SOPORTE_ADDI_EN
      S_ADDI_EXEC: estado_d = S_ADDI_WB;
      S_ADDI_WB:   estado_d = S_FETCH;
`endif
      default:     estado_d = S_FETCH;
    endcase
  end

  // State register; reset abandons any in-progress memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= S_FETCH;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Control outputs decoded from the current state; FETCH write enables wait for mem_listo.
  always_comb begin
    pc_escritura      = 1'b0;
    pc_escritura_cond = 1'b0;
    iord              = 1'b0;
    mem_lectura       = 1'b0;
    mem_escritura     = 1'b0;
    ir_escritura      = 1'b0;
    mem_a_reg         = 1'b0;
    reg_escritura     = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_B;
    pc_fuente         = PCF_ALU;
    operacion_alu     = ALU_ADD;
    op_invalida       = 1'b0;
    case (estado_q)
      S_FETCH: begin
        mem_lectura   = 1'b1;
        alu_src_b     = SRCB_CUATRO;
        operacion_alu = ALU_ADD;
        ir_escritura  = mem_listo;
        pc_escritura  = mem_listo;
      end
      S_DECODE: begin
        alu_src_b     = SRCB_IMMSH;
        operacion_alu = ALU_ADD;
        op_invalida   = ~opcode_valido;
      end
      S_MEM_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        operacion_alu = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_lectura = 1'b1;
        iord        = 1'b1;
      end
      S_MEM_WB: begin
        reg_escritura = 1'b1;
        mem_a_reg     = 1'b1;
        reg_dst       = 1'b0;
      end
      S_MEM_WRITE: begin
        mem_escritura = 1'b1;
        iord          = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        operacion_alu = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_escritura = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_src_b         = SRCB_B;
        operacion_alu     = ALU_SUB;
        pc_escritura_cond = 1'b1;
        pc_fuente         = PCF_ALUOUT;
      end
      S_JUMP: begin
        pc_escritura = 1'b1;
        pc_fuente    = PCF_JUMP;
      end
`ifdef SOPORTE_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        operacion_alu = ALU_ADD;
      end
      S_ADDI_WB: begin
        reg_escritura = 1'b1;
        reg_dst       = 1'b0;
        mem_a_reg     = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign estado = estado_q;

endmodule
